// File: rtl/uart_cfg_core.sv
// -----------------------------------------------------------------------------
// uart_cfg_core
// Parametrised full-duplex UART core. The frame is a start bit (0), then
// DATA_WIDTH data bits LSB first, then an optional parity bit, then STOP_BITS
// stop bits (1). The receiver oversamples the line and rejects short glitches.
// It reports parity and framing errors together with a one-cycle rx_valid.
//
// Parameters
//   CLK_FREQ    system clock in Hz
//   BAUD_RATE   line rate in bit/s
//   DATA_WIDTH  data bits per frame (5..9)
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   1 or 2
//   OVERSAMPLE  RX samples per bit (even, >= 4)
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   start          TX request, only looked at while TX is idle
//   tx_data_in     TX payload, captured on the accepted start cycle
//   tx             serial output, idles high
//   tx_active      high while a TX frame is in progress
//   done_tx        one-cycle pulse at the end of the last stop bit
//   rx             serial input, asynchronous to clk
//   rx_data_out    last received payload, held until the next rx_valid
//   rx_valid       one-cycle pulse when a frame completes
//   rx_parity_err  parity mismatch for the frame, updated with rx_valid
//   rx_frame_err   a stop bit was sampled low, updated with rx_valid
//
// TX states
//   state      | meaning
//   TX_IDLE    | line high, waiting for start
//   TX_START   | driving the start bit
//   TX_DATA    | driving data bits, LSB first
//   TX_PARITY  | driving the parity bit
//   TX_STOP    | driving stop bit(s)
//
// RX states
//   state         | meaning
//   RX_IDLE       | waiting for a high-to-low transition
//   RX_START      | half a bit in, confirming the start bit
//   RX_DATA       | sampling data bits mid-bit
//   RX_PARITY     | sampling the parity bit
//   RX_STOP       | sampling stop bit(s), then reporting the frame
//   RX_WAIT_IDLE  | break seen, waiting for the line to go high again
// -----------------------------------------------------------------------------
module uart_cfg_core #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    output logic                  tx,
    output logic                  tx_active,
    output logic                  done_tx,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

    localparam int OS_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;
    localparam int BIT_CLKS   = OS_DIV * OVERSAMPLE;
    localparam int OSD_W      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int TXC_W      = $clog2(BIT_CLKS);
    localparam int RXC_W      = $clog2(OVERSAMPLE);
    localparam int IDX_W      = $clog2(DATA_WIDTH);

    localparam logic [OSD_W-1:0] OSD_LAST  = OSD_W'(OS_DIV - 1);
    localparam logic [TXC_W-1:0] TXC_LAST  = TXC_W'(BIT_CLKS - 1);
    localparam logic [RXC_W-1:0] RXC_HALF  = RXC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [RXC_W-1:0] RXC_LAST  = RXC_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    // ------------------------------------------------------------------
    // Oversample tick: one-cycle pulse every OS_DIV clocks (RX only)
    // ------------------------------------------------------------------
    logic [OSD_W-1:0] r_os_cnt;
    logic             r_os_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_os_cnt  <= '0;
            r_os_tick <= 1'b0;
        end else if (r_os_cnt == '0) begin
            r_os_cnt  <= OSD_LAST;
            r_os_tick <= 1'b1;
        end else begin
            r_os_cnt  <= r_os_cnt - OSD_W'(1);
            r_os_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // TX times bits with its own clock down-counter reloaded on acceptance,
    // so bit boundaries do not depend on the free-running os_tick phase.
    // ------------------------------------------------------------------
    tx_state_t             r_tx_state;
    logic [TXC_W-1:0]      r_tx_cnt;
    logic [IDX_W-1:0]      r_tx_idx;
    logic                  r_tx_stop_idx;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_tx_par;
    logic                  r_tx;
    logic                  r_tx_active;
    logic                  r_done_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state    <= TX_IDLE;
            r_tx_cnt      <= '0;
            r_tx_idx      <= '0;
            r_tx_stop_idx <= 1'b0;
            r_tx_shift    <= '0;
            r_tx_par      <= 1'b0;
            r_tx          <= 1'b1;
            r_tx_active   <= 1'b0;
            r_done_tx     <= 1'b0;
        end else begin
            r_done_tx <= 1'b0;
            if (r_tx_state == TX_IDLE) begin
                if (start) begin
                    r_tx_shift  <= tx_data_in;
                    r_tx_par    <= (PARITY == 1) ? ~^tx_data_in : ^tx_data_in;
                    r_tx_cnt    <= TXC_LAST;
                    r_tx        <= 1'b0;
                    r_tx_active <= 1'b1;
                    r_tx_state  <= TX_START;
                end
            end else if (r_tx_cnt != '0) begin
                r_tx_cnt <= r_tx_cnt - TXC_W'(1);
            end else begin
                // End of the current bit: set up the next one.
                r_tx_cnt <= TXC_LAST;
                case (r_tx_state)
                    TX_START: begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
                        r_tx_idx   <= '0;
                        r_tx_state <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (r_tx_idx == IDX_LAST) begin
                            if (PARITY != 0) begin
                                r_tx       <= r_tx_par;
                                r_tx_state <= TX_PARITY;
                            end else begin
                                r_tx          <= 1'b1;
                                r_tx_stop_idx <= 1'b0;
                                r_tx_state    <= TX_STOP;
                            end
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
                            r_tx_idx   <= r_tx_idx + IDX_W'(1);
                        end
                    end
                    TX_PARITY: begin
                        r_tx          <= 1'b1;
                        r_tx_stop_idx <= 1'b0;
                        r_tx_state    <= TX_STOP;
                    end
                    TX_STOP: begin
                        if (r_tx_stop_idx == STOP_LAST) begin
                            r_tx_active <= 1'b0;
                            r_done_tx   <= 1'b1;
                            r_tx_state  <= TX_IDLE;
                        end else begin
                            r_tx_stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        r_tx        <= 1'b1;
                        r_tx_active <= 1'b0;
                        r_tx_state  <= TX_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver front end: 2-flop synchroniser plus one delayed copy used
    // for falling-edge detection. The flops reset high so that reset
    // release does not look like a start edge.
    // ------------------------------------------------------------------
    logic r_rx_s1;
    logic r_rx_s2;
    logic r_rx_prev;
    logic w_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx = r_rx_s2;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t             r_rx_state;
    logic [RXC_W-1:0]      r_rx_cnt;
    logic [IDX_W-1:0]      r_rx_idx;
    logic                  r_rx_stop_idx;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic                  r_rx_par_bit;
    logic                  r_rx_ferr_acc;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_rx_perr;
    logic                  r_rx_ferr;
    logic                  w_rx_par_exp;

    assign w_rx_par_exp = (PARITY == 1) ? ~^r_rx_shift : ^r_rx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state    <= RX_IDLE;
            r_rx_cnt      <= '0;
            r_rx_idx      <= '0;
            r_rx_stop_idx <= 1'b0;
            r_rx_shift    <= '0;
            r_rx_par_bit  <= 1'b0;
            r_rx_ferr_acc <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_perr     <= 1'b0;
            r_rx_ferr     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !w_rx) begin
                        r_rx_cnt   <= RXC_HALF;
                        r_rx_state <= RX_START;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (w_rx) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    if (r_os_tick) begin
                        if (r_rx_cnt != '0) begin
                            r_rx_cnt <= r_rx_cnt - RXC_W'(1);
                        end else begin
                            // Sample point; the next one is a full bit later.
                            r_rx_cnt <= RXC_LAST;
                            case (r_rx_state)
                                RX_START: begin
                                    if (w_rx) begin
                                        r_rx_state <= RX_IDLE;
                                    end else begin
                                        r_rx_idx      <= '0;
                                        r_rx_ferr_acc <= 1'b0;
                                        r_rx_state    <= RX_DATA;
                                    end
                                end
                                RX_DATA: begin
                                    r_rx_shift <= {w_rx, r_rx_shift[DATA_WIDTH-1:1]};
                                    if (r_rx_idx == IDX_LAST) begin
                                        r_rx_stop_idx <= 1'b0;
                                        r_rx_state    <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                                    end else begin
                                        r_rx_idx <= r_rx_idx + IDX_W'(1);
                                    end
                                end
                                RX_PARITY: begin
                                    r_rx_par_bit <= w_rx;
                                    r_rx_state   <= RX_STOP;
                                end
                                RX_STOP: begin
                                    if (r_rx_stop_idx == STOP_LAST) begin
                                        r_rx_data  <= r_rx_shift;
                                        r_rx_valid <= 1'b1;
                                        r_rx_perr  <= (PARITY != 0) && (r_rx_par_bit != w_rx_par_exp);
                                        r_rx_ferr  <= r_rx_ferr_acc | ~w_rx;
                                        // A low final stop bit is treated as a break.
                                        r_rx_state <= w_rx ? RX_IDLE : RX_WAIT_IDLE;
                                    end else begin
                                        if (!w_rx) begin
                                            r_rx_ferr_acc <= 1'b1;
                                        end
                                        r_rx_stop_idx <= 1'b1;
                                    end
                                end
                                default: begin
                                    r_rx_state <= RX_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign tx            = r_tx;
    assign tx_active     = r_tx_active;
    assign done_tx       = r_done_tx;
    assign rx_data_out   = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_parity_err = r_rx_perr;
    assign rx_frame_err  = r_rx_ferr;

endmodule

// File: tb/tb_uart_cfg_core.sv
`timescale 1ns/1ps
module tb_uart_cfg_core;

    // Reduced line rate keeps the run short: OS_DIV = 2, bit time = 32 clocks.
    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int OSR      = 16;
    localparam int BIT      = 32;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b, start_c;
    logic [7:0] data_a, data_b, data_c;
    logic       tx_a, act_a, done_a;
    logic       tx_b, act_b, done_b;
    logic       tx_c, act_c, done_c;
    logic       loop_a, rx_drv_a, rx_drv_c;
    logic       rx_a, rx_b, rx_c;
    logic [7:0] rxd_a, rxd_b, rxd_c;
    logic       rxv_a, rxv_b, rxv_c;
    logic       pe_a, pe_b, pe_c;
    logic       fe_a, fe_b, fe_c;

    logic       sel;
    logic       mon_tx, mon_act, mon_done;

    assign rx_a = loop_a ? tx_a : rx_drv_a;
    assign rx_b = tx_b;
    assign rx_c = rx_drv_c;
    assign mon_tx   = sel ? tx_b   : tx_a;
    assign mon_act  = sel ? act_b  : act_a;
    assign mon_done = sel ? done_b : done_a;

    // A: 8N1, B: even parity + 2 stop, C: odd parity (RX only)
    uart_cfg_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_WIDTH(8),
                    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OSR)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .tx_data_in(data_a),
        .tx(tx_a), .tx_active(act_a), .done_tx(done_a), .rx(rx_a),
        .rx_data_out(rxd_a), .rx_valid(rxv_a), .rx_parity_err(pe_a), .rx_frame_err(fe_a));

    uart_cfg_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_WIDTH(8),
                    .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(OSR)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_data_in(data_b),
        .tx(tx_b), .tx_active(act_b), .done_tx(done_b), .rx(rx_b),
        .rx_data_out(rxd_b), .rx_valid(rxv_b), .rx_parity_err(pe_b), .rx_frame_err(fe_b));

    uart_cfg_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_WIDTH(8),
                    .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(OSR)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .tx_data_in(data_c),
        .tx(tx_c), .tx_active(act_c), .done_tx(done_c), .rx(rx_c),
        .rx_data_out(rxd_c), .rx_valid(rxv_c), .rx_parity_err(pe_c), .rx_frame_err(fe_c));

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt_a = 0, cnt_b = 0, cnt_c = 0;

    // Scoreboard: every rx_valid pops and compares against the queued result.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rxv_a) begin
            cnt_a++;
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL rx_a_unexpected: got data=%h pe=%b fe=%b, required no rx_valid", rxd_a, pe_a, fe_a);
            end else begin
                e = q_a.pop_front();
                if ({rxd_a, pe_a, fe_a} !== e) begin
                    n_fail++;
                    $display("FAIL rx_a_frame: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                             rxd_a, pe_a, fe_a, e.d, e.pe, e.fe);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rxv_b) begin
            cnt_b++;
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL rx_b_unexpected: got data=%h pe=%b fe=%b, required no rx_valid", rxd_b, pe_b, fe_b);
            end else begin
                e = q_b.pop_front();
                if ({rxd_b, pe_b, fe_b} !== e) begin
                    n_fail++;
                    $display("FAIL rx_b_frame: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                             rxd_b, pe_b, fe_b, e.d, e.pe, e.fe);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (rxv_c) begin
            cnt_c++;
            n_checks++;
            if (q_c.size() == 0) begin
                n_fail++;
                $display("FAIL rx_c_unexpected: got data=%h pe=%b fe=%b, required no rx_valid", rxd_c, pe_c, fe_c);
            end else begin
                e = q_c.pop_front();
                if ({rxd_c, pe_c, fe_c} !== e) begin
                    n_fail++;
                    $display("FAIL rx_c_frame: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                             rxd_c, pe_c, fe_c, e.d, e.pe, e.fe);
                end
            end
        end
    end

    // Line-level frame model: bit 0 = start, unused upper bits stay idle-high.
    function automatic logic [15:0] fb(input logic [7:0] d, input bit hp, input logic pb,
                                       input int ns, input logic sv);
        logic [15:0] f;
        int k;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        k = 9;
        if (hp) begin
            f[k] = pb;
            k++;
        end
        for (int s = 0; s < ns; s++) f[k+s] = sv;
        return f;
    endfunction

    // Start a frame on A (s=0) or B (s=1) and check tx/tx_active/done_tx every cycle.
    task automatic send_check(input bit s, input logic [7:0] d, input logic [15:0] f,
                              input int nb, input bit spam, input string nm);
        bit   bad;
        logic bt, ba, bd;
        sel = s;
        @(negedge clk);
        if (s) begin start_b = 1'b1; data_b = d; end
        else   begin start_a = 1'b1; data_a = d; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bad = 1'b0; bt = 1'b0; ba = 1'b0; bd = 1'b0;
            for (int c = 0; c < BIT; c++) begin
                if (!bad && (mon_tx !== f[b] || mon_act !== 1'b1 || mon_done !== 1'b0)) begin
                    bad = 1'b1; bt = mon_tx; ba = mon_act; bd = mon_done;
                end
                if (spam) begin
                    start_a = ((c % 11) == 3);
                    data_a  = ~d;
                end
                @(posedge clk); #1;
            end
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s bit %0d: tx=%b active=%b done=%b, required tx=%b active=1 done=0",
                         nm, b, bt, ba, bd, f[b]);
            end
        end
        start_a = 1'b0;
        n_checks++;
        if (mon_done !== 1'b1 || mon_act !== 1'b0 || mon_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end: done=%b active=%b tx=%b, required done=1 active=0 tx=1",
                     nm, mon_done, mon_act, mon_tx);
        end
        @(posedge clk); #1;
        n_checks++;
        if (mon_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: done=%b one cycle later, required 0", nm, mon_done);
        end
    endtask

    // Drive a frame on rx of A (s=0) or C (s=1); line is left at the last bit.
    task automatic drive_frame(input bit s, input logic [15:0] f, input int nb);
        for (int b = 0; b < nb; b++) begin
            if (s) rx_drv_c = f[b];
            else   rx_drv_a = f[b];
            repeat (BIT) @(posedge clk);
        end
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && k < 4 * BIT) begin
            @(posedge clk);
            k++;
        end
        n_checks++;
        if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
            n_fail++;
            $display("FAIL %s timeout: %0d frames still pending, required 0", nm,
                     q_a.size() + q_b.size() + q_c.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({tx_a, act_a, done_a, rxv_a, rxd_a, pe_a, fe_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: tx=%b act=%b done=%b v=%b d=%h pe=%b fe=%b, required tx=1 rest 0",
                     tx_a, act_a, done_a, rxv_a, rxd_a, pe_a, fe_a);
        end
        n_checks++;
        if ({tx_b, act_b, done_b, rxv_b, rxd_b, pe_b, fe_b} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: tx=%b act=%b done=%b v=%b d=%h pe=%b fe=%b, required tx=1 rest 0",
                     tx_b, act_b, done_b, rxv_b, rxd_b, pe_b, fe_b);
        end
        n_checks++;
        if ({tx_c, act_c, done_c, rxv_c, rxd_c, pe_c, fe_c} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_c: tx=%b act=%b done=%b v=%b d=%h pe=%b fe=%b, required tx=1 rest 0",
                     tx_c, act_c, done_c, rxv_c, rxd_c, pe_c, fe_c);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_loopback_8n1();
        loop_a = 1'b1;
        q_a.push_back({8'hA5, 1'b0, 1'b0});
        send_check(1'b0, 8'hA5, fb(8'hA5, 1'b0, 1'b0, 1, 1'b1), 10, 1'b0, "tx_a5");
        wait_drain("rx_a5");
    endtask

    task automatic test_even_2stop();
        logic [7:0] d;
        d = 8'h07;
        q_b.push_back({d, 1'b0, 1'b0});
        send_check(1'b1, d, fb(d, 1'b1, ^d, 2, 1'b1), 12, 1'b0, "tx_07_e2");
        wait_drain("rx_07_e2");
    endtask

    task automatic test_odd_parity();
        logic [7:0] d;
        logic       pb;
        d  = 8'h3C;
        pb = ~^d;
        q_c.push_back({d, 1'b0, 1'b0});
        drive_frame(1'b1, fb(d, 1'b1, pb, 1, 1'b1), 11);
        repeat (BIT) @(posedge clk);
        wait_drain("rx_3c_good");
        q_c.push_back({d, 1'b1, 1'b0});
        drive_frame(1'b1, fb(d, 1'b1, ~pb, 1, 1'b1), 11);
        repeat (BIT) @(posedge clk);
        wait_drain("rx_3c_bad");
    endtask

    task automatic test_break();
        int c0;
        loop_a   = 1'b0;
        rx_drv_a = 1'b1;
        repeat (BIT) @(posedge clk);
        c0 = cnt_a;
        q_a.push_back({8'h55, 1'b0, 1'b1});
        drive_frame(1'b0, fb(8'h55, 1'b0, 1'b0, 1, 1'b0), 10);
        repeat (3 * BIT) @(posedge clk);
        n_checks++;
        if (cnt_a - c0 != 1) begin
            n_fail++;
            $display("FAIL break_hold: %0d rx_valid during break, required 1", cnt_a - c0);
        end
        rx_drv_a = 1'b1;
        repeat (BIT) @(posedge clk);
        q_a.push_back({8'h12, 1'b0, 1'b0});
        drive_frame(1'b0, fb(8'h12, 1'b0, 1'b0, 1, 1'b1), 10);
        repeat (BIT) @(posedge clk);
        wait_drain("rx_12_after_break");
        n_checks++;
        if (cnt_a - c0 != 2) begin
            n_fail++;
            $display("FAIL break_recover: %0d rx_valid total, required 2", cnt_a - c0);
        end
    endtask

    task automatic test_glitch();
        int c0;
        c0 = cnt_a;
        @(negedge clk);
        rx_drv_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv_a = 1'b1;
        repeat (3 * BIT) @(posedge clk);
        n_checks++;
        if (cnt_a != c0) begin
            n_fail++;
            $display("FAIL glitch: %0d rx_valid after glitch, required 0", cnt_a - c0);
        end
    endtask

    task automatic test_back_to_back();
        int  c0;
        bit  bad;
        loop_a = 1'b1;
        q_a.push_back({8'h5A, 1'b0, 1'b0});
        send_check(1'b0, 8'h5A, fb(8'h5A, 1'b0, 1'b0, 1, 1'b1), 10, 1'b1, "tx_spam");
        bad = 1'b0;
        for (int i = 0; i < 2 * BIT; i++) begin
            if (tx_a !== 1'b1 || act_a !== 1'b0 || done_a !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL spam_idle: extra TX activity after frame, required idle line");
        end
        wait_drain("rx_spam");
        c0 = cnt_a;
        q_a.push_back({8'h81, 1'b0, 1'b0});
        q_a.push_back({8'h7E, 1'b0, 1'b0});
        send_check(1'b0, 8'h81, fb(8'h81, 1'b0, 1'b0, 1, 1'b1), 10, 1'b0, "tx_b2b_1");
        send_check(1'b0, 8'h7E, fb(8'h7E, 1'b0, 1'b0, 1, 1'b1), 10, 1'b0, "tx_b2b_2");
        wait_drain("rx_b2b");
        n_checks++;
        if (cnt_a - c0 != 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d frames received, required 2", cnt_a - c0);
        end
    endtask

    task automatic test_reset_midframe();
        int c0;
        loop_a = 1'b1;
        sel    = 1'b0;
        c0     = cnt_a;
        @(negedge clk);
        start_a = 1'b1;
        data_a  = 8'h2C;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #1;
        n_checks++;
        if (tx_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_bit4: tx=%b in data bit 4 of 0x2C, required 0", tx_a);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (tx_a !== 1'b1 || act_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: tx=%b active=%b after reset edge, required tx=1 active=0", tx_a, act_a);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * BIT) @(posedge clk);
        n_checks++;
        if (cnt_a != c0) begin
            n_fail++;
            $display("FAIL mid_reset_rx: %0d rx_valid from aborted frame, required 0", cnt_a - c0);
        end
        q_a.push_back({8'hC3, 1'b0, 1'b0});
        send_check(1'b0, 8'hC3, fb(8'hC3, 1'b0, 1'b0, 1, 1'b1), 10, 1'b0, "tx_c3");
        wait_drain("rx_c3");
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        data_a = 8'h00; data_b = 8'h00; data_c = 8'h00;
        loop_a = 1'b0; rx_drv_a = 1'b1; rx_drv_c = 1'b1;
        sel = 1'b0;
        test_reset();
        test_loopback_8n1();
        test_even_2stop();
        test_odd_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        repeat (BIT) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
